// File: rtl/trojan_resp_capture.sv
// trojan_resp_capture
//
// Response-capture engine at the receiving end of the benchmark stimulus path.
// After an accepted start it waits SETTLE idle cycles, samples dut_out on WIN
// consecutive rising edges, and compresses the samples into a SIG_W-bit
// signature. The signature is then offered on a valid/ready port.
//
// Build option:
//   TRJ_CAP_RAW_EN  undefined: Galois MISR compression with feedback POLY.
//                   defined:   plain shift register, sig_data holds the last
//                              min(WIN, SIG_W) raw samples, newest in bit 0.
//
// Ports:
//   CK          clock, all state on the rising edge
//   reset       asynchronous, active-low reset
//   start       capture request, accepted only when idle
//   dut_out     observed DUT output bit
//   busy        high while settling or capturing
//   sample_cnt  samples taken in the current/last window
//   sig_valid   signature available
//   sig_ready   consumer accepts the signature
//   sig_data    signature, stable while sig_valid is high

module trojan_resp_capture #(
    parameter int unsigned      SIG_W  = 16,
    parameter int unsigned      WIN    = 16,
    parameter int unsigned      SETTLE = 1,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(16'h1021)
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             dut_out,
    output logic             busy,
    output logic [15:0]      sample_cnt,
    output logic             sig_valid,
    input  logic             sig_ready,
    output logic [SIG_W-1:0] sig_data
);

    // Elaboration-time parameter check.
    if (SIG_W < 4 || WIN < 1 || WIN > 65535 || SETTLE > 255) begin : g_param_err
        $error("trojan_resp_capture: illegal parameter value");
    end

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StSettle  = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;
    localparam logic [1:0] StHold    = 2'd3;

    localparam logic [15:0] WinCnt     = 16'(WIN);
    localparam logic [15:0] WinLast    = 16'(WIN - 1);
    localparam logic [7:0]  SettleLoad = 8'(SETTLE);
    localparam bit          SkipSettle = (SETTLE == 0);

    logic [1:0]       state_q, state_d;
    logic [7:0]       settle_q, settle_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [SIG_W-1:0] sig_next;

`ifdef TRJ_CAP_RAW_EN
    // Raw mode: no feedback, POLY intentionally unused.
    logic unused_poly;
    assign unused_poly = ^POLY;
    assign sig_next = {sig_q[SIG_W-2:0], dut_out};
`else
    assign sig_next = {sig_q[SIG_W-2:0], 1'b0}
                    ^ (sig_q[SIG_W-1] ? POLY : '0)
                    ^ {{(SIG_W-1){1'b0}}, dut_out};
`endif

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        sig_d    = sig_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    sig_d    = '0;
                    cnt_d    = '0;
                    settle_d = SettleLoad;
                    state_d  = SkipSettle ? StCapture : StSettle;
                end
            end
            StSettle: begin
                settle_d = settle_q - 8'd1;
                if (settle_q == 8'd1) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                sig_d = sig_next;
                if (cnt_q != WinCnt) begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (cnt_q == WinLast) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                // A start in the same cycle as the handshake is dropped.
                if (sig_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            settle_q <= '0;
            cnt_q    <= '0;
            sig_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            sig_q    <= sig_d;
        end
    end

    // Outputs come straight from flops: no path from sig_ready or dut_out.
    assign busy       = (state_q == StSettle) || (state_q == StCapture);
    assign sig_valid  = (state_q == StHold);
    assign sample_cnt = cnt_q;
    assign sig_data   = sig_q;

endmodule

// File: tb/tb_trojan_resp_capture.sv
// Bench for trojan_resp_capture: a default instance (SETTLE=1, WIN=16) with
// randomized captures checked against a polynomial-arithmetic reference, and a
// second instance (SETTLE=0, WIN=1) for the shortest window.

module tb_trojan_resp_capture;

    localparam int unsigned SIG_W  = 16;
    localparam int unsigned WIN    = 16;
    localparam int unsigned SETTLE = 1;
    localparam logic [15:0] POLY   = 16'h1021;

    logic        CK = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, dut_out = 1'b0, sig_ready = 1'b0;
    logic        busy, sig_valid;
    logic [15:0] sample_cnt;
    logic [15:0] sig_data;

    logic        start1 = 1'b0, dout1 = 1'b0, ready1 = 1'b0;
    logic        busy1, valid1;
    logic [15:0] cnt1;
    logic [15:0] sig1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CK = ~CK;

    trojan_resp_capture #(
        .SIG_W  (SIG_W),
        .WIN    (WIN),
        .SETTLE (SETTLE),
        .POLY   (POLY)
    ) dut (
        .CK         (CK),
        .reset      (reset),
        .start      (start),
        .dut_out    (dut_out),
        .busy       (busy),
        .sample_cnt (sample_cnt),
        .sig_valid  (sig_valid),
        .sig_ready  (sig_ready),
        .sig_data   (sig_data)
    );

    trojan_resp_capture #(
        .SIG_W  (16),
        .WIN    (1),
        .SETTLE (0),
        .POLY   (POLY)
    ) dut_w1 (
        .CK         (CK),
        .reset      (reset),
        .start      (start1),
        .dut_out    (dout1),
        .busy       (busy1),
        .sample_cnt (cnt1),
        .sig_valid  (valid1),
        .sig_ready  (ready1),
        .sig_data   (sig1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // x * p mod (x^16 + POLY)
    function automatic logic [15:0] mulx(input logic [15:0] p);
        return {p[14:0], 1'b0} ^ (p[15] ? POLY : 16'h0);
    endfunction

    // bits[0] is the first sample taken.
    function automatic logic [15:0] model_sig(input logic [WIN-1:0] bits);
        logic [15:0] r;
        r = '0;
`ifdef TRJ_CAP_RAW_EN
        for (int i = 0; i < int'(WIN); i++) begin
            if (int'(WIN) - 1 - i < 16) r[int'(WIN) - 1 - i] = bits[i];
        end
`else
        // Sum of b_i * x^(WIN-1-i) reduced modulo the feedback polynomial.
        begin
            logic [15:0] pw;
            pw = 16'h0001;
            for (int j = 0; j < int'(WIN); j++) begin
                if (bits[int'(WIN) - 1 - j]) r ^= pw;
                pw = mulx(pw);
            end
        end
`endif
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_valid"}, sig_valid, 0);
        check_eq({tag, "_sig"}, sig_data, 0);
        check_eq({tag, "_cnt"}, sample_cnt, 0);
        check_eq({tag, "_w1_busy"}, busy1, 0);
        check_eq({tag, "_w1_valid"}, valid1, 0);
    endtask

    // Full capture on the main instance. Called at a negedge with the DUT idle.
    task automatic run_capture(input logic [WIN-1:0] bits, input int hold_wait,
                               input bit start_with_ready);
        logic [15:0] exp_sig;
        int          last;
        int          exp_cnt;
        exp_sig = model_sig(bits);
        last    = int'(SETTLE + WIN) + 1;
        start     = 1'b1;
        dut_out   = 1'($urandom);
        sig_ready = 1'($urandom);
        for (int n = 1; n <= last; n++) begin
            @(negedge CK);
            exp_cnt = n - 1 - int'(SETTLE);
            if (exp_cnt < 0) exp_cnt = 0;
            if (exp_cnt > int'(WIN)) exp_cnt = int'(WIN);
            check_eq("cap_busy", busy, (n <= last - 1) ? 1 : 0);
            check_eq("cap_valid", sig_valid, (n == last) ? 1 : 0);
            check_eq("cap_cnt", sample_cnt, exp_cnt);
            if (n == last) check_eq("cap_sig", sig_data, exp_sig);
            start     = 1'($urandom);
            sig_ready = 1'($urandom);
            if (n >= int'(SETTLE) + 1 && n <= int'(SETTLE + WIN)) begin
                dut_out = bits[n - int'(SETTLE) - 1];
            end else begin
                dut_out = 1'($urandom);
            end
        end
        for (int h = 0; h < hold_wait; h++) begin
            sig_ready = 1'b0;
            start     = 1'($urandom);
            @(negedge CK);
            check_eq("hold_valid", sig_valid, 1);
            check_eq("hold_busy", busy, 0);
            check_eq("hold_sig", sig_data, exp_sig);
            check_eq("hold_cnt", sample_cnt, WIN);
        end
        sig_ready = 1'b1;
        start     = start_with_ready;
        @(negedge CK);
        check_eq("ack_valid", sig_valid, 0);
        check_eq("ack_busy", busy, 0);
        check_eq("ack_sig_kept", sig_data, exp_sig);
        sig_ready = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        logic [WIN-1:0] bits;
        #5 reset = 1'b0;
        @(negedge CK);
        check_idle_outputs("reset");
        @(negedge CK);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CK);
            check_idle_outputs("idle");
        end

        // Impulse: only the first sample is 1.
        run_capture(16'h0001, 0, 1'b0);
        check_eq("impulse_sig", sig_data, 16'h8000);

        // Alternating 1,0,1,0 with backpressure and start pulses in HOLD.
        run_capture(16'h5555, 5, 1'b1);
`ifdef TRJ_CAP_RAW_EN
        check_eq("raw_alt_sig", sig_data, 16'hAAAA);
`endif

        for (int r = 0; r < 6; r++) begin
            @(negedge CK);
            run_capture(WIN'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
        end

        // Reset after 8 samples, then a full window.
        @(negedge CK);
        bits  = WIN'($urandom);
        start = 1'b1;
        for (int n = 1; n <= int'(SETTLE) + 9; n++) begin
            @(negedge CK);
            start   = 1'b0;
            dut_out = (n >= int'(SETTLE) + 1) ? bits[n - int'(SETTLE) - 1] : 1'b0;
        end
        check_eq("pre_rst_cnt", sample_cnt, 8);
        #1 reset = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_cnt", sample_cnt, 0);
        check_eq("midrst_sig", sig_data, 0);
        check_eq("midrst_valid", sig_valid, 0);
        @(negedge CK);
        reset = 1'b1;
        @(negedge CK);
        run_capture(WIN'($urandom), 2, 1'b0);

        // Shortest window: SETTLE=0, WIN=1.
        for (int r = 0; r < 4; r++) begin
            logic b;
            b = (r == 0) ? 1'b1 : 1'($urandom);
            @(negedge CK);
            start1 = 1'b1;
            dout1  = 1'($urandom);
            @(negedge CK);
            check_eq("w1_busy", busy1, 1);
            check_eq("w1_valid_early", valid1, 0);
            start1 = 1'b0;
            dout1  = b;
            @(negedge CK);
            check_eq("w1_valid", valid1, 1);
            check_eq("w1_busy_hold", busy1, 0);
            check_eq("w1_sig", sig1, {15'h0, b});
            check_eq("w1_cnt", cnt1, 1);
            ready1 = 1'b1;
            @(negedge CK);
            check_eq("w1_ack_valid", valid1, 0);
            ready1 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
